// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider with glitch-free ratio updates and a global phase-align sync.
// Optional rise strobes are enabled with `define CLKDIV_BANK_RISE_STROBE_EN.
module clock_divider_bank #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int RESET_HALF = 1,
    parameter int CH_W       = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              sync,
    output logic [NUM_CH-1:0] div_clock,
    output logic [NUM_CH-1:0] div_rise
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CH_W-1:0]    pend_ch_r;
    logic [CNT_W-1:0]   pend_half_r;
    logic               ready_r;
    logic [CNT_W-1:0]   half_r [NUM_CH];
    logic [CNT_W-1:0]   cnt_r  [NUM_CH];
    logic [NUM_CH-1:0]  lvl_r;
    logic [NUM_CH-1:0]  wrap_s;
    logic [NUM_CH-1:0]  commit_s;
    logic               commit_any_s;
    logic               in_range_s;
    logic               accept_s;

    // Per-channel terminal count and commit qualification (falling edge, disabled, or sync).
    always_comb begin
        wrap_s   = {NUM_CH{1'b0}};
        commit_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            wrap_s[k] = (half_r[k] != {CNT_W{1'b0}}) &&
                        (cnt_r[k] == (half_r[k] - {{(CNT_W-1){1'b0}}, 1'b1}));
            if ((state_r == ST_PENDING) && (pend_ch_r == CH_W'(k))) begin
                commit_s[k] = sync || (half_r[k] == {CNT_W{1'b0}}) || (wrap_s[k] && lvl_r[k]);
            end else begin
                commit_s[k] = 1'b0;
            end
        end
        commit_any_s = |commit_s;
        in_range_s   = ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CH));
    end

    // Configuration FSM next-state; out-of-range requests are acknowledged but dropped.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid && in_range_s) begin
                    state_nxt_s = ST_PENDING;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (commit_any_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Configuration FSM state, pending slot and registered ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            pend_ch_r   <= {CH_W{1'b0}};
            pend_half_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            if (accept_s) begin
                pend_ch_r   <= cfg_ch;
                pend_half_r <= cfg_half;
            end else begin
                pend_ch_r   <= pend_ch_r;
                pend_half_r <= pend_half_r;
            end
        end
    end

    // Channel counters and levels; a commit takes priority over sync for the target channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                half_r[k] <= CNT_W'(RESET_HALF);
                cnt_r[k]  <= {CNT_W{1'b0}};
                lvl_r[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (commit_s[k]) begin
                    half_r[k] <= pend_half_r;
                    cnt_r[k]  <= {CNT_W{1'b0}};
                    lvl_r[k]  <= 1'b0;
                end else if (sync || (half_r[k] == {CNT_W{1'b0}})) begin
                    cnt_r[k]  <= {CNT_W{1'b0}};
                    lvl_r[k]  <= 1'b0;
                end else if (wrap_s[k]) begin
                    cnt_r[k]  <= {CNT_W{1'b0}};
                    lvl_r[k]  <= ~lvl_r[k];
                end else begin
                    cnt_r[k]  <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef CLKDIV_BANK_RISE_STROBE_EN
    logic [NUM_CH-1:0] rise_r;

    // Rise strobe coincides with the first cycle a channel reads high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise_r <= {NUM_CH{1'b0}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                rise_r[k] <= wrap_s[k] && !lvl_r[k] && !sync && !commit_s[k];
            end
        end
    end

    assign div_rise = rise_r;
`else
    assign div_rise = {NUM_CH{1'b0}};
`endif

    assign div_clock = lvl_r;
    assign cfg_ready = ready_r;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: the driver pushes per-edge expectations, a negedge monitor compares.
module tb_clock_divider_bank;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 8;
    localparam int RESET_HALF = 1;
    localparam int CH_W       = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              sync;
    logic [NUM_CH-1:0] div_clock;
    logic [NUM_CH-1:0] div_rise;

    typedef struct packed {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] rise;
        logic              ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int                m_h [NUM_CH];
    int                m_n [NUM_CH];
    bit                m_pend = 1'b0;
    int                m_pch = 0;
    int                m_phalf = 0;
    logic [NUM_CH-1:0] m_prev = '0;
    bit                last_accept = 1'b0;

    clock_divider_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(RESET_HALF), .CH_W(CH_W)
    ) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_half(cfg_half), .sync(sync),
        .div_clock(div_clock), .div_rise(div_rise)
    );

    always #5 clock = ~clock;

    // Level after n edges since a restart: low for h edges, then high for h, repeating.
    function automatic bit lvl(input int h, input int n);
        return (h != 0) && (((n / h) % 2) == 1);
    endfunction

    task automatic hand(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply inputs for the next edge, advance the reference, queue the expectation.
    task automatic step(input bit rst, input bit v, input int ch, input int half, input bit sy);
        exp_t              e;
        logic [NUM_CH-1:0] clk_e;
        bit                c_k;
        bit                committed;
        reset     = rst;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_half  = CNT_W'(half);
        sync      = sy;
        last_accept = 1'b0;
        committed   = 1'b0;
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_h[k] = RESET_HALF;
                m_n[k] = 0;
            end
            m_pend = 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                c_k = m_pend && (k == m_pch) &&
                      (sy || (m_h[k] == 0) || (lvl(m_h[k], m_n[k]) && !lvl(m_h[k], m_n[k] + 1)));
                if (c_k) begin
                    m_h[k] = m_phalf;
                    m_n[k] = 0;
                    committed = 1'b1;
                end else if (sy || (m_h[k] == 0)) begin
                    m_n[k] = 0;
                end else begin
                    m_n[k] = m_n[k] + 1;
                end
            end
            if (m_pend) begin
                if (committed) m_pend = 1'b0;
            end else if (v) begin
                last_accept = 1'b1;
                if (ch < NUM_CH) begin
                    m_pend  = 1'b1;
                    m_pch   = ch;
                    m_phalf = half;
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) clk_e[k] = lvl(m_h[k], m_n[k]);
        e.clk = clk_e;
`ifdef CLKDIV_BANK_RISE_STROBE_EN
        e.rise = clk_e & ~m_prev;
`else
        e.rise = '0;
`endif
        e.ready = !m_pend;
        m_prev  = clk_e;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Hold a request until the handshake happens; sync only accompanies the first attempt.
    task automatic cfg(input int ch, input int half, input bit sy);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, ch, half, sy && (i == 0));
            if (last_accept) break;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            if (!m_pend) break;
            step(1'b0, 1'b0, 0, 0, 1'b0);
        end
    endtask

    // Monitor: every negedge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (div_clock !== e.clk) begin
                    errors++;
                    $display("FAIL div_clock: got %b expected %b at %0t", div_clock, e.clk, $time);
                end
                checks++;
                if (div_rise !== e.rise) begin
                    errors++;
                    $display("FAIL div_rise: got %b expected %b at %0t", div_rise, e.rise, $time);
                end
                checks++;
                if (cfg_ready !== e.ready) begin
                    errors++;
                    $display("FAIL cfg_ready: got %b expected %b at %0t", cfg_ready, e.ready, $time);
                end
            end
        end
    end

    initial begin
        logic [NUM_CH-1:0] rise_all;
`ifdef CLKDIV_BANK_RISE_STROBE_EN
        rise_all = 4'b1111;
`else
        rise_all = 4'b0000;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            m_h[k] = RESET_HALF;
            m_n[k] = 0;
        end
        // Reset, then free-running divide-by-2.
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        hand("reset_clk", 32'(div_clock), 32'h0);
        hand("reset_ready", 32'(cfg_ready), 32'h1);
        idle(1);
        hand("first_edge_clk", 32'(div_clock), 32'hF);
        hand("first_edge_rise", 32'(div_rise), 32'(rise_all));
        idle(1);
        hand("second_edge_clk", 32'(div_clock), 32'h0);
        idle(5);

        // ch1 half=3 requested while ch1 reads high.
        cfg(1, 3, 1'b0);
        hand("ready_drop", 32'(cfg_ready), 32'h0);
        wait_idle();
        idle(14);

        // Disable ch2, then restart it at half 2.
        cfg(2, 0, 1'b0);
        wait_idle();
        idle(6);
        cfg(2, 2, 1'b0);
        wait_idle();
        idle(8);

        // Halves 1,2,4,4 then a one-cycle sync.
        cfg(1, 2, 1'b0);
        wait_idle();
        cfg(2, 4, 1'b0);
        wait_idle();
        cfg(3, 4, 1'b0);
        wait_idle();
        idle(3);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        hand("sync_clk", 32'(div_clock), 32'h0);
        idle(1);
        hand("sync_plus1", 32'(div_clock), 32'b0001);
        idle(1);
        hand("sync_plus2", 32'(div_clock), 32'b0010);
        idle(2);
        hand("sync_plus4", 32'(div_clock), 32'b1100);
        idle(10);

        // Pending ch3 half=5 committed by sync.
        cfg(3, 5, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        hand("sync_commit_ready", 32'(cfg_ready), 32'h1);
        idle(4);
        hand("ch3_low_4", 32'(div_clock[3]), 32'h0);
        idle(1);
        hand("ch3_rise_5", 32'(div_clock[3]), 32'h1);
        idle(8);

        // Sync coincident with an IDLE handshake.
        cfg(2, 3, 1'b1);
        hand("sync_cfg_ready", 32'(cfg_ready), 32'h0);
        wait_idle();
        idle(10);

        // Out-of-range channel is accepted and dropped.
        step(1'b0, 1'b1, 7, 9, 1'b0);
        hand("oor_ready", 32'(cfg_ready), 32'h1);
        idle(4);

        // Reset while a config is pending.
        cfg(0, 6, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        hand("rst_pend_clk", 32'(div_clock), 32'h0);
        hand("rst_pend_ready", 32'(cfg_ready), 32'h1);
        idle(6);

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Multi-channel programmable clock divider, the parametrised successor to the fixed divide-by-2 divider.
- Generates NUM_CH divided clock outputs from one master clock.
- Each channel's half-period is runtime-configurable through a valid/ready port. New ratios are committed glitch-free at the channel's next falling transition.
- A global sync input phase-aligns all channels, e.g. for the imem, dmem and regfile clocks.

Parameters:
- NUM_CH, 4, number of divided clock channels (1..16).
- CNT_W, 8, width of the half-period field and per-channel counter.
- RESET_HALF, 1, half-period loaded into every channel on reset (1 = divide-by-2).
- CH_W, 2, width of cfg_ch. Must satisfy 2**CH_W >= NUM_CH.

Ports:
- clock  in  1  master clock. All logic runs on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  bank can accept a configuration request.
- cfg_ch  in  CH_W  target channel index.
- cfg_half  in  CNT_W  new half-period in master cycles. 0 = channel disabled (held low).
- sync  in  1  one-cycle request to restart all channels phase-aligned.
- div_clock  out  NUM_CH  divided clock outputs, registered.
- div_rise  out  NUM_CH  one-cycle strobe per channel, asserted in the cycle div_clock[k] goes 0->1.

Behaviour:
- Per-channel state: half register H[k], counter C[k], level L[k]. div_clock[k] = L[k].
- Reset: H=RESET_HALF, C=0, L=0 for every channel; div_rise=0; cfg_ready=1; FSM=IDLE; pending slot cleared.
- Normal counting (H[k]!=0), each edge:
  - If C==H-1: C<=0, L<=~L.
  - Else: C<=C+1.
  - Output period = 2*H master cycles at 50% duty.
- Disabled channel (H[k]==0): C<=0, L<=0, div_rise[k]=0.
- With RESET_HALF=1: the first edge after reset deasserts drives all div_clock to 1; the outputs then toggle every cycle.
- div_rise[k] <= (H!=0) && (C==H-1) && !L. It is registered, so it is high exactly in the cycle L[k] reads 1 after a low phase.
- Config FSM has two states, IDLE and PENDING.
  - IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) with cfg_ch < NUM_CH latches {ch, half} and moves to PENDING; cfg_ready is 0 from the next cycle.
  - IDLE, out-of-range channel: a handshake with cfg_ch >= NUM_CH is accepted and dropped; no state change.
  - PENDING: commit on the edge where the target channel would go high->low (C==H-1 && L==1), or on the first PENDING edge if current H==0.
  - Commit action: H<=new half, C<=0, L<=0. FSM returns to IDLE; cfg_ready=1 the cycle after commit.
  - Commit to 0 disables the channel. Commit from 0 restarts the channel low: first rise after new H cycles.
- Glitch-free guarantee: no high or low phase ever shorter than min(old H, new H).
- sync (IDLE or PENDING):
  - On the edge sampling sync=1, all channels get C<=0, L<=0.
  - If PENDING, the pending config is committed on that same edge and the FSM returns to IDLE.
  - After sync, all enabled channels with equal H produce identical waveforms.
- Simultaneous sync and cfg handshake in IDLE: sync is applied and the config is latched into PENDING. Commit occurs at the next falling transition.
- Reset has priority over sync and cfg. Reset mid-PENDING discards the pending config.
- Counter compare uses CNT_W-bit unsigned arithmetic. H=2**CNT_W-1 is the maximum supported half-period; no wrap beyond it.

Optional Feature:
- Macro CLKDIV_BANK_RISE_STROBE_EN.
- Defined: div_rise is generated as described above.
- Undefined: div_rise port still exists but is tied to all-zero, and the strobe logic is removed.
- Clock and config behaviour are identical in both builds.

Test Plan:
- Reset release, NUM_CH=4, RESET_HALF=1 -> all div_clock toggle every cycle, first value 1 one edge after reset low. div_rise (macro on) high on alternate cycles in phase with div_clock=1.
- cfg ch1 half=3 while div_clock[1]=1:
  - cfg_ready drops next cycle.
  - Commit at the falling transition; ch1 then shows low 3, high 3 (period 6).
  - Channels 0, 2, 3 unchanged; cfg_ready returns 1 the cycle after commit.
- cfg ch2 half=0 -> ch2 goes low at its next falling transition and stays 0; div_rise[2]=0. Then cfg ch2 half=2 -> ch2 rises exactly 2 cycles after commit.
- Channels at half 1, 2, 4, 4 free-running; pulse sync for one cycle -> next edge all outputs 0, counters 0. Channels 2 and 3 identical thereafter; all rise in cycles 1, 2, 4 after sync.
- cfg ch3 half=5 pending, assert sync before the falling transition -> commit on the sync edge, FSM IDLE, ch3 rises 5 cycles later. A separate run with cfg_ch=7 -> accepted, no change, cfg_ready stays 1.
- Assert reset mid-PENDING -> all outputs 0, H back to RESET_HALF, pending config lost, cfg_ready=1.
